// File: rtl/lfsr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr_pkg                                                   |
// | Description : Shared definitions for the LFSR random generator: maximal- |
// |               length Fibonacci tap masks for widths 3..32, the draw FSM  |
// |               state type and the legal parameter limits.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lfsr_pkg;

  // Legal parameter limits
  localparam int unsigned c_min_width     = 3;
  localparam int unsigned c_max_width     = 32;
  localparam int unsigned c_min_max_tries = 1;

  // Draw handshake states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } fsm_e;

  // Feedback mask for a shift-left Fibonacci LFSR. Bit k-1 set means tap k
  // (1-based, counted from the newest bit) feeds the XOR. Every entry gives a
  // maximal period of 2**width - 1. Unsupported widths return 0.
  function automatic logic [31:0] tap_mask(input int unsigned width);
    logic [31:0] mask;
    mask = 32'h0;
    case (width)
      3:       mask = 32'h0000_0006;
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      6:       mask = 32'h0000_0030;
      7:       mask = 32'h0000_0060;
      8:       mask = 32'h0000_00B8;
      9:       mask = 32'h0000_0110;
      10:      mask = 32'h0000_0240;
      11:      mask = 32'h0000_0500;
      12:      mask = 32'h0000_0829;
      13:      mask = 32'h0000_100D;
      14:      mask = 32'h0000_2015;
      15:      mask = 32'h0000_6000;
      16:      mask = 32'h0000_D008;
      17:      mask = 32'h0001_2000;
      18:      mask = 32'h0002_0400;
      19:      mask = 32'h0004_0023;
      20:      mask = 32'h0009_0000;
      21:      mask = 32'h0014_0000;
      22:      mask = 32'h0030_0000;
      23:      mask = 32'h0042_0000;
      24:      mask = 32'h00E1_0000;
      25:      mask = 32'h0120_0000;
      26:      mask = 32'h0200_0023;
      27:      mask = 32'h0400_0013;
      28:      mask = 32'h0900_0000;
      29:      mask = 32'h1400_0000;
      30:      mask = 32'h2000_0029;
      31:      mask = 32'h4800_0000;
      32:      mask = 32'h8020_0003;
      default: mask = 32'h0;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr_core                                                  |
// | Description : Fibonacci LFSR state register with seed load and zero-seed |
// |               guard. A load wins over a step in the same cycle.          |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk     - system clock                                     |
// |               rst_n   - asynchronous active-low reset                    |
// |               step_i  - advance the LFSR by one step                     |
// |               load_i  - load seed_i (zero is replaced by 1)              |
// |               seed_i  - seed value                                       |
// |               state_o - current LFSR state                               |
// +--------------------------------------------------------------------------+
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter logic [31:0] SEED  = 32'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [31:0]      c_mask32      = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] c_mask        = c_mask32[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_seed_trunc  = SEED[WIDTH-1:0];
  // Guard applied after truncation so a SEED whose low bits are all zero
  // cannot lock the register in the dead state.
  localparam logic [WIDTH-1:0] c_reset_state = (c_seed_trunc == '0) ? WIDTH'(1) : c_seed_trunc;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             w_fb;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_seed_guarded;

  assign w_fb           = ^(state_q & c_mask);
  assign w_step         = {state_q[WIDTH-2:0], w_fb};
  assign w_seed_guarded = (seed_i == '0) ? WIDTH'(1) : seed_i;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = w_seed_guarded;
    end else if (step_i) begin
      state_d = w_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_reset_state;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/lfsr_rng.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr_rng                                                   |
// | Description : Parametrised LFSR random generator with free-run enable,   |
// |               runtime seed load and a req/valid handshake returning a    |
// |               uniform value in [0, RANGE-1] by rejection sampling, with  |
// |               a fallback to 0 after MAX_TRIES rejects.                   |
// | Revision    : 1.0 - initial release                                      |
// | Option      : LFSR_REJECT_CNT_EN adds reject_cnt_o, a saturating 16-bit  |
// |               count of all rejected candidates since reset.              |
// | Ports       : clk, rst_n   - clock, asynchronous active-low reset        |
// |               en           - free-run step enable while idle             |
// |               seed_load    - load seed_in this cycle                     |
// |               seed_in      - new seed (0 loads as 1)                     |
// |               req          - request one ranged value (idle only)        |
// |               busy_o       - draw in progress                            |
// |               valid_o      - one-cycle pulse, value_o is new             |
// |               value_o      - result, held until the next valid_o         |
// |               timeout_o    - pulses with valid_o when fallback was used  |
// |               state_o      - raw LFSR state                              |
// |               reject_cnt_o - (optional) rejected candidate count         |
// +--------------------------------------------------------------------------+
module lfsr_rng
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned OUT_W     = 4,
  parameter int unsigned RANGE     = 10,
  parameter int unsigned SEED      = 1,
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             busy_o,
  output logic             valid_o,
  output logic [OUT_W-1:0] value_o,
  output logic             timeout_o,
  output logic [WIDTH-1:0] state_o
`ifdef LFSR_REJECT_CNT_EN
  ,
  output logic [15:0]      reject_cnt_o
`endif
);

  localparam int unsigned        c_cnt_w     = $clog2(MAX_TRIES + 1);
  localparam logic [c_cnt_w-1:0] c_max_tries = c_cnt_w'(MAX_TRIES);
  // One extra bit so RANGE == 2**OUT_W is representable in the compare.
  localparam logic [OUT_W:0]     c_range     = (OUT_W + 1)'(RANGE);
  localparam bit c_params_ok =
      (WIDTH >= c_min_width) && (WIDTH <= c_max_width) &&
      (OUT_W >= 1) && (OUT_W <= WIDTH) &&
      (RANGE >= 1) && (64'(RANGE) <= (64'd1 << OUT_W)) &&
      (MAX_TRIES >= c_min_max_tries);

  fsm_e               fsm_q;
  logic               busy_q;
  logic               valid_q;
  logic               timeout_q;
  logic [OUT_W-1:0]   value_q;
  logic [c_cnt_w-1:0] try_cnt_q;

  logic [WIDTH-1:0]   w_state;
  logic               w_step;
  logic [OUT_W-1:0]   w_cand;
  logic               w_accept;
  logic [c_cnt_w-1:0] w_try_inc;
  logic               w_reject;

  assign w_step    = (fsm_q == DRAW) || ((fsm_q == IDLE) && en);
  assign w_cand    = w_state[OUT_W-1:0];
  assign w_accept  = ({1'b0, w_cand} < c_range);
  assign w_try_inc = try_cnt_q + c_cnt_w'(1);
  // A seed load discards the DRAW attempt of that cycle, so it is not a reject.
  assign w_reject  = (fsm_q == DRAW) && !seed_load && !w_accept;

  lfsr_core #(
    .WIDTH (WIDTH),
    .SEED  (32'(SEED))
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_i  (w_step),
    .load_i  (seed_load),
    .seed_i  (seed_in),
    .state_o (w_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      value_q   <= '0;
      try_cnt_q <= '0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (req) begin
            fsm_q     <= DRAW;
            busy_q    <= 1'b1;
            try_cnt_q <= '0;
          end
        end
        DRAW: begin
          if (!seed_load) begin
            if (w_accept) begin
              value_q <= w_cand;
              valid_q <= 1'b1;
              fsm_q   <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              try_cnt_q <= w_try_inc;
              if (w_try_inc == c_max_tries) begin
                value_q   <= '0;
                valid_q   <= 1'b1;
                timeout_q <= 1'b1;
                fsm_q     <= IDLE;
                busy_q    <= 1'b0;
              end
            end
          end
        end
        default: begin
          fsm_q  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef LFSR_REJECT_CNT_EN
  logic [15:0] rej_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_cnt_q <= '0;
    end else if (w_reject && (rej_cnt_q != 16'hFFFF)) begin
      rej_cnt_q <= rej_cnt_q + 16'd1;
    end
  end

  assign reject_cnt_o = rej_cnt_q;
`else
  logic w_unused_reject;
  assign w_unused_reject = w_reject;
`endif

`ifndef SYNTHESIS
  a_params_legal: assert property (@(posedge clk) disable iff (!rst_n) c_params_ok);
`endif

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign value_o   = value_q;
  assign timeout_o = timeout_q;
  assign state_o   = w_state;

endmodule
`default_nettype wire
